// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: load-use, branch, multi-cycle and memory-wait control
// for the PC and pipeline registers, plus a saturating stall counter.
module hazard_stall_unit #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mc_start,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN,
    MC,
    MEMW
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 2);

  state_t     state;
  state_t     ret_state;
  state_t     state_nx;
  state_t     ret_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       freeze;
  logic       lu_hit;
  logic       rs_hit;
  logic       rt_hit;

  assign freeze = mem_req && !mem_ready;
  assign rs_hit = id_uses_rs && (id_rs == id_ex_rt);
  assign rt_hit = id_uses_rt && (id_rt == id_ex_rt);
  assign lu_hit = id_ex_memread && (id_ex_rt != 5'd0)
                  && (rs_hit || rt_hit);

  assign mc_busy = rst_n && (state == MC) && (cnt != 4'd0);

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    state_nx      = state;
    ret_nx        = ret_state;
    cnt_nx        = cnt;

    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
      state_nx      = MEMW;
      if (state != MEMW) ret_nx = state;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (ex_mc_start) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            cnt_nx        = CNT_INIT;
            // MC_LAT=2 still passes through MC so the held start is
            // not re-taken on the release cycle
            state_nx      = MC;
          end else if (lu_hit) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MC: begin
          if (cnt != 4'd0) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            cnt_nx        = cnt - 4'd1;
          end else begin
            state_nx = RUN;
          end
        end
        MEMW: state_nx = ret_state;
        default: state_nx = RUN;
      endcase
    end

    if (!rst_n) begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_write  = 1'b1;
      ex_mem_bubble = 1'b0;
      mem_wb_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      ret_state   <= RUN;
      cnt         <= 4'd0;
      stall_count <= '0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      cnt       <= cnt_nx;
      if (!pc_write && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with an expected-value queue and
// a small stall-counter model; a CNT_W=4 copy covers saturation.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] id_rs, id_rt, id_ex_rt;
  logic       id_uses_rs, id_uses_rt, id_ex_memread;
  logic       ex_mc_start, ex_branch_taken, mem_req, mem_ready;

  logic        pc_write, if_id_write, if_id_flush, id_ex_write;
  logic        id_ex_bubble, ex_mem_write, ex_mem_bubble;
  logic        mem_wb_bubble, mc_busy;
  logic [15:0] stall_count;

  logic       s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write;
  logic       s_id_ex_bubble, s_ex_mem_write, s_ex_mem_bubble;
  logic       s_mem_wb_bubble, s_mc_busy;
  logic [3:0] s_stall_count;

  hazard_stall_unit #(.MC_LAT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .ex_mc_start(ex_mc_start), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
    .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
    .mc_busy(mc_busy), .stall_count(stall_count)
  );

  hazard_stall_unit #(.MC_LAT(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .ex_mc_start(ex_mc_start), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush), .id_ex_write(s_id_ex_write),
    .id_ex_bubble(s_id_ex_bubble), .ex_mem_write(s_ex_mem_write),
    .ex_mem_bubble(s_ex_mem_bubble), .mem_wb_bubble(s_mem_wb_bubble),
    .mc_busy(s_mc_busy), .stall_count(s_stall_count)
  );

  // {pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, exmem_bub,
  //  memwb_bub, mc_busy}
  localparam logic [8:0] DEF    = 9'b110101000;
  localparam logic [8:0] LU     = 9'b000111000;
  localparam logic [8:0] BR     = 9'b111111000;
  localparam logic [8:0] MCS    = 9'b000001100;
  localparam logic [8:0] MCB    = 9'b000001101;
  localparam logic [8:0] FRZ    = 9'b000000010;
  localparam logic [8:0] FRZ_MC = 9'b000000011;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ecnt   = 0;
  int   ecnt4  = 0;

  wire [8:0] ctrl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                     id_ex_bubble, ex_mem_write, ex_mem_bubble,
                     mem_wb_bubble, mc_busy};
  wire [8:0] s_ctrl = {s_pc_write, s_if_id_write, s_if_id_flush,
                       s_id_ex_write, s_id_ex_bubble, s_ex_mem_write,
                       s_ex_mem_bubble, s_mem_wb_bubble, s_mc_busy};

  task automatic cyc(input logic [8:0] e, input string tag);
    exp_t x;
    exp_t y;
    x.ctrl = e;
    x.cnt  = 16'(ecnt);
    x.cnt4 = 4'(ecnt4);
    q.push_back(x);
    #2;
    y = q.pop_front();
    n_chk++;
    assert (ctrl === y.ctrl) else begin
      n_fail++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, ctrl, y.ctrl);
    end
    n_chk++;
    assert (stall_count === y.cnt) else begin
      n_fail++;
      $error("FAIL %s stall_count observed=%0d expected=%0d",
             tag, stall_count, y.cnt);
    end
    n_chk++;
    assert (s_ctrl === y.ctrl) else begin
      n_fail++;
      $error("FAIL %s sat_ctrl observed=%b expected=%b",
             tag, s_ctrl, y.ctrl);
    end
    n_chk++;
    assert (s_stall_count === y.cnt4) else begin
      n_fail++;
      $error("FAIL %s sat_count observed=%0d expected=%0d",
             tag, s_stall_count, y.cnt4);
    end
    @(posedge clk);
    if (!rst_n) begin
      ecnt  = 0;
      ecnt4 = 0;
    end else if (!e[8]) begin
      if (ecnt < 65535) ecnt++;
      if (ecnt4 < 15) ecnt4++;
    end
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_ex_memread = 1'b0;
    ex_mc_start = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    // outputs forced to default under reset despite hazards
    mem_req = 1'b1; ex_branch_taken = 1'b1; ex_mc_start = 1'b1;
    cyc(DEF, "reset_forced");
    idle();
    rst_n = 1'b1;
    cyc(DEF, "idle");

    // load-use on rs, then clear
    id_ex_memread = 1'b1; id_ex_rt = 5'd5;
    id_rs = 5'd5; id_uses_rs = 1'b1;
    cyc(LU, "lu_rs");
    id_ex_memread = 1'b0;
    cyc(DEF, "lu_clear");
    // load-use on rt
    id_ex_memread = 1'b1; id_ex_rt = 5'd7;
    id_rt = 5'd7; id_uses_rt = 1'b1; id_uses_rs = 1'b0;
    cyc(LU, "lu_rt");
    // r0 never hazards
    id_ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    cyc(DEF, "lu_r0");
    // match without a read is not a hazard
    id_ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd3;
    id_uses_rs = 1'b0; id_uses_rt = 1'b1;
    cyc(DEF, "lu_nouse");
    idle();

    // multi-cycle op held four cycles
    ex_mc_start = 1'b1;
    cyc(MCS, "mc_entry");
    cyc(MCB, "mc_c2");
    cyc(MCB, "mc_c3");
    cyc(DEF, "mc_release");
    ex_mc_start = 1'b0;
    cyc(DEF, "mc_after");

    // memory wait from RUN
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc(FRZ, "frz_1");
    cyc(FRZ, "frz_2");
    cyc(FRZ, "frz_3");
    mem_ready = 1'b1;
    cyc(DEF, "frz_exit");
    mem_req = 1'b0;
    cyc(DEF, "frz_after");

    // memory wait in the middle of a multi-cycle op
    ex_mc_start = 1'b1;
    cyc(MCS, "mcf_entry");
    cyc(MCB, "mcf_c2");
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc(FRZ_MC, "mcf_frz1");
    cyc(FRZ, "mcf_frz2");
    cyc(FRZ, "mcf_frz3");
    mem_ready = 1'b1;
    cyc(DEF, "mcf_exit");
    mem_req = 1'b0;
    cyc(MCB, "mcf_resume");
    cyc(DEF, "mcf_release");
    ex_mc_start = 1'b0;
    cyc(DEF, "mcf_after");

    // branch beats load-use and multi-cycle
    ex_branch_taken = 1'b1; id_ex_memread = 1'b1;
    id_ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    cyc(BR, "br_lu");
    id_ex_memread = 1'b0; ex_mc_start = 1'b1;
    cyc(BR, "br_mc");
    idle();
    cyc(DEF, "br_after");

    // reset in the middle of a multi-cycle op
    ex_mc_start = 1'b1;
    cyc(MCS, "rmc_entry");
    cyc(MCB, "rmc_c2");
    rst_n = 1'b0;
    cyc(DEF, "rmc_reset");
    rst_n = 1'b1; ex_mc_start = 1'b0;
    cyc(DEF, "rmc_post");

    // saturation: 20 stall cycles
    id_ex_memread = 1'b1; id_ex_rt = 5'd5;
    id_rs = 5'd5; id_uses_rs = 1'b1;
    repeat (20) cyc(LU, "sat_stall");
    idle();
    cyc(DEF, "sat_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
